// File: rtl/lpc_io_periph.sv
// LPC I/O-cycle peripheral: decodes host I/O read/write cycles against a
// maskable address window and forwards hits to a local register block over a
// request/ready handshake, inserting long-wait SYNCs and an error SYNC on timeout.
//
// Ports:
//   clk_i, nrst_i        LPC clock, async active-low reset
//   lframe_i, lad_i      LFRAME# and LAD sampled from the pins
//   lad_o, lad_oe_o      LAD drive value and active-high output enable
//   addr_o, wdata_o      latched cycle address and write data
//   wr_o, rd_o           one-clock request pulses to the local side
//   rdata_i, ready_i     local read data and completion
//   err_o                one-clock pulse when error SYNC is issued
//   state_o              current FSM state (debug)
module lpc_io_periph #(
   parameter logic [15:0] BASE_ADDR = 16'h0080,
   parameter logic [15:0] ADDR_MASK = 16'hFFFF,
   parameter int unsigned MAX_WAIT  = 8
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        lframe_i,
   input  logic [3:0]  lad_i,
   output logic [3:0]  lad_o,
   output logic        lad_oe_o,
   output logic [15:0] addr_o,
   output logic [7:0]  wdata_o,
   output logic        wr_o,
   output logic        rd_o,
   input  logic [7:0]  rdata_i,
   input  logic        ready_i,
   output logic        err_o,
   output logic [4:0]  state_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   localparam logic [4:0] IDLE      = 5'd0;
   localparam logic [4:0] START     = 5'd1;
   localparam logic [4:0] CYC       = 5'd2;
   localparam logic [4:0] ADDR0     = 5'd3;
   localparam logic [4:0] ADDR1     = 5'd4;
   localparam logic [4:0] ADDR2     = 5'd5;
   localparam logic [4:0] ADDR3     = 5'd6;
   localparam logic [4:0] WDATA_L   = 5'd7;
   localparam logic [4:0] WDATA_H   = 5'd8;
   localparam logic [4:0] TAR1      = 5'd9;
   localparam logic [4:0] TAR2      = 5'd10;
   localparam logic [4:0] SYNC_WAIT = 5'd11;
   localparam logic [4:0] SYNC_OK   = 5'd12;
   localparam logic [4:0] SYNC_ERR  = 5'd13;
   localparam logic [4:0] RDATA_L   = 5'd14;
   localparam logic [4:0] RDATA_H   = 5'd15;
   localparam logic [4:0] PTAR1     = 5'd16;
   localparam logic [4:0] PTAR2     = 5'd17;

   logic [4:0]       state;
   logic [4:0]       state_nxt;
   logic             is_wr;
   logic             hit;
   logic             hit_now;
   logic             abort;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       rlatch;

   assign state_o = state;

   // State register
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and LAD drive decode
   always_comb begin
      state_nxt = state;
      lad_oe_o  = 1'b1;
      lad_o     = 4'hF;
      abort     = !lframe_i && (state != IDLE) && (state != START);
      // Address compare uses the nibble arriving in ADDR3 as the low bits
      hit_now   = (({addr_o[15:4], lad_i} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

      if (abort) begin
         state_nxt = (lad_i == 4'h0) ? START : IDLE;
      end else begin
         case (state)
            IDLE:      if (!lframe_i && lad_i == 4'h0) state_nxt = START;
            START: begin
               if (!lframe_i)                            state_nxt = (lad_i == 4'h0) ? START : IDLE;
               else if (lad_i == 4'h0 || lad_i == 4'h2) state_nxt = ADDR0;
               else                                      state_nxt = IDLE;
            end
            CYC:       state_nxt = IDLE;
            ADDR0:     state_nxt = ADDR1;
            ADDR1:     state_nxt = ADDR2;
            ADDR2:     state_nxt = ADDR3;
            ADDR3: begin
               if (is_wr)        state_nxt = WDATA_L;
               else if (hit_now) state_nxt = TAR1;
               else              state_nxt = IDLE;
            end
            WDATA_L:   state_nxt = WDATA_H;
            WDATA_H:   state_nxt = hit ? TAR1 : IDLE;
            TAR1:      state_nxt = TAR2;
            TAR2:      state_nxt = ready_i ? SYNC_OK : SYNC_WAIT;
            SYNC_WAIT: begin
               if (ready_i)             state_nxt = SYNC_OK;
               else if (cnt == CNT_MAX) state_nxt = SYNC_ERR;
            end
            SYNC_OK,
            SYNC_ERR:  state_nxt = is_wr ? PTAR1 : RDATA_L;
            RDATA_L:   state_nxt = RDATA_H;
            RDATA_H:   state_nxt = PTAR1;
            PTAR1:     state_nxt = PTAR2;
            PTAR2:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end

      case (state)
         SYNC_WAIT: lad_o = 4'h6;
         SYNC_OK:   lad_o = 4'h0;
         SYNC_ERR:  lad_o = 4'hA;
         RDATA_L:   lad_o = rlatch[3:0];
         RDATA_H:   lad_o = rlatch[7:4];
         PTAR1:     lad_o = 4'hF;
         default:   lad_oe_o = 1'b0;
      endcase
   end

   // Cycle latches, wait counter and request/error pulses
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         is_wr   <= 1'b0;
         hit     <= 1'b0;
         addr_o  <= 16'h0000;
         wdata_o <= 8'h00;
         cnt     <= '0;
         rlatch  <= 8'h00;
         wr_o    <= 1'b0;
         rd_o    <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         // Pulses are keyed on the next state so an abort suppresses them
         wr_o  <= (state_nxt == TAR1) && is_wr;
         rd_o  <= (state_nxt == TAR1) && !is_wr;
         err_o <= (state_nxt == SYNC_ERR);

         if (state == START && lframe_i) is_wr <= (lad_i == 4'h2);

         if (!abort) begin
            case (state)
               ADDR0:   addr_o[15:12] <= lad_i;
               ADDR1:   addr_o[11:8]  <= lad_i;
               ADDR2:   addr_o[7:4]   <= lad_i;
               ADDR3: begin
                  addr_o[3:0] <= lad_i;
                  hit         <= hit_now;
               end
               WDATA_L: wdata_o[3:0] <= lad_i;
               WDATA_H: wdata_o[7:4] <= lad_i;
               default: ;
            endcase
         end

         // Counter starts at 1 for the first long-wait nibble and saturates
         if (state == TAR2)
            cnt <= (state_nxt == SYNC_WAIT) ? CNT_W'(1) : '0;
         else if (state == SYNC_WAIT && state_nxt == SYNC_WAIT && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);

         if ((state == TAR2 || state == SYNC_WAIT) && state_nxt == SYNC_OK)
            rlatch <= rdata_i;
         else if (state_nxt == SYNC_ERR)
            rlatch <= 8'hFF;
      end
   end

endmodule

// File: tb/tb_lpc_io_periph.sv
// Self-checking bench for lpc_io_periph. Two instances share the host-side
// inputs: one with a full address mask, one ignoring address bits [3:0].
// Expected LAD nibble sequences are built from the protocol rules per transaction.
module tb_lpc_io_periph;

   localparam logic [15:0] BASE   = 16'h0080;
   localparam logic [15:0] MASK_A = 16'hFFFF;
   localparam logic [15:0] MASK_B = 16'hFFF0;
   localparam int          MAXW   = 8;

   logic        clk = 1'b0;
   logic        nrst;
   logic        lframe;
   logic [3:0]  lad_in;
   logic [7:0]  rdata;
   logic        ready;
   logic        sel;

   logic [3:0]  a_lad, b_lad;
   logic        a_oe, b_oe, a_wr, b_wr, a_rd, b_rd, a_err, b_err;
   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic [4:0]  a_state, b_state;

   logic [3:0]  o_lad;
   logic        o_oe, o_wr, o_rd, o_err;
   logic [15:0] o_addr;
   logic [7:0]  o_wdata;

   int errs   = 0;
   int checks = 0;

   always #15 clk = ~clk;

   lpc_io_periph #(.BASE_ADDR(BASE), .ADDR_MASK(MASK_A), .MAX_WAIT(MAXW)) dut_a (
      .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
      .lad_o(a_lad), .lad_oe_o(a_oe), .addr_o(a_addr), .wdata_o(a_wdata),
      .wr_o(a_wr), .rd_o(a_rd), .rdata_i(rdata), .ready_i(ready),
      .err_o(a_err), .state_o(a_state));

   lpc_io_periph #(.BASE_ADDR(BASE), .ADDR_MASK(MASK_B), .MAX_WAIT(MAXW)) dut_b (
      .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
      .lad_o(b_lad), .lad_oe_o(b_oe), .addr_o(b_addr), .wdata_o(b_wdata),
      .wr_o(b_wr), .rd_o(b_rd), .rdata_i(rdata), .ready_i(ready),
      .err_o(b_err), .state_o(b_state));

   // Observe the selected instance
   always_comb begin
      o_lad   = sel ? b_lad   : a_lad;
      o_oe    = sel ? b_oe    : a_oe;
      o_wr    = sel ? b_wr    : a_wr;
      o_rd    = sel ? b_rd    : a_rd;
      o_err   = sel ? b_err   : a_err;
      o_addr  = sel ? b_addr  : a_addr;
      o_wdata = sel ? b_wdata : a_wdata;
   end

   // Drive one host nibble, then sample just after the edge that consumed it
   task automatic step(input logic lf, input logic [3:0] nib);
      lframe = lf;
      lad_in = nib;
      @(posedge clk);
      #1;
   endtask

   // One complete host I/O cycle with inline checks against the protocol rules.
   // rdy_k: edge index (0 = turnaround exit) at which ready_i is first high.
   // abort_k: edge index at which the host aborts (-1 = none).
   task automatic run_io(input string nm, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input int rdy_k, input logic [7:0] rd,
                         input int abort_k, input bit rst_rdl);
      logic [15:0] mask;
      bit          hit, err_exp;
      int          n_wait;
      logic [7:0]  d;
      logic [3:0]  exp_q[$];
      mask  = sel ? MASK_B : MASK_A;
      hit   = ((addr & mask) == (BASE & mask));
      ready = 1'b0;
      rdata = 8'($urandom);
      step(1'b0, 4'h0);
      step(1'b1, wr ? 4'h2 : 4'h0);
      for (int i = 3; i >= 0; i--) step(1'b1, addr[i*4 +: 4]);
      if (wr) begin
         step(1'b1, wd[3:0]);
         step(1'b1, wd[7:4]);
      end
      checks++;
      if ({o_oe, o_rd, o_wr, o_err} !== {1'b0, !wr && hit, wr && hit, 1'b0}) begin
         errs++;
         $display("FAIL %s req: oe/rd/wr/err got %b want %b", nm,
                  {o_oe, o_rd, o_wr, o_err}, {1'b0, !wr && hit, wr && hit, 1'b0});
      end
      checks++;
      if (o_addr !== addr || (wr && o_wdata !== wd)) begin
         errs++;
         $display("FAIL %s latch: addr/wdata got %h/%h want %h/%h", nm, o_addr, o_wdata, addr, wd);
      end
      if (!hit) begin
         for (int j = 0; j < 3; j++) begin
            step(1'b1, 4'hF);
            checks++;
            if ({o_oe, o_rd, o_wr, o_err} !== 4'b0000) begin
               errs++;
               $display("FAIL %s miss: oe/rd/wr/err got %b want 0000", nm, {o_oe, o_rd, o_wr, o_err});
            end
         end
         return;
      end
      step(1'b1, 4'hF);
      checks++;
      if ({o_oe, o_rd, o_wr, o_err} !== 4'b0000) begin
         errs++;
         $display("FAIL %s tar: oe/rd/wr/err got %b want 0000", nm, {o_oe, o_rd, o_wr, o_err});
      end

      n_wait  = (rdy_k <= MAXW) ? rdy_k : MAXW;
      err_exp = (rdy_k > MAXW);
      for (int i = 0; i < n_wait; i++) exp_q.push_back(4'h6);
      exp_q.push_back(err_exp ? 4'hA : 4'h0);
      if (!wr) begin
         d = err_exp ? 8'hFF : rd;
         exp_q.push_back(d[3:0]);
         exp_q.push_back(d[7:4]);
      end
      exp_q.push_back(4'hF);

      for (int k = 0; k < exp_q.size(); k++) begin
         ready = (k == rdy_k);
         rdata = ready ? rd : 8'($urandom);
         if (k == abort_k) begin
            ready = 1'b1;
            step(1'b0, 4'hF);
            ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               checks++;
               if ({o_oe, o_rd, o_wr, o_err} !== 4'b0000) begin
                  errs++;
                  $display("FAIL %s abort: oe/rd/wr/err got %b want 0000", nm, {o_oe, o_rd, o_wr, o_err});
               end
               step(1'b1, 4'hF);
            end
            return;
         end
         step(1'b1, 4'hF);
         checks++;
         if ({o_oe, o_lad, o_rd, o_wr, o_err} !== {1'b1, exp_q[k], 2'b00, err_exp && (k == n_wait)}) begin
            errs++;
            $display("FAIL %s sync[%0d]: oe/lad/rd/wr/err got %b want %b", nm, k,
                     {o_oe, o_lad, o_rd, o_wr, o_err}, {1'b1, exp_q[k], 2'b00, err_exp && (k == n_wait)});
         end
         if (rst_rdl && !wr && k == n_wait + 1) begin
            #2 nrst = 1'b0;
            #1;
            checks++;
            if ({o_oe, o_lad, o_rd, o_wr, o_err, o_addr, o_wdata} !== {1'b0, 4'hF, 3'b000, 16'h0000, 8'h00}) begin
               errs++;
               $display("FAIL %s reset: oe/lad/rd/wr/err/addr/wdata got %b %h %b %h %h want 0 f 000 0000 00",
                        nm, o_oe, o_lad, {o_rd, o_wr, o_err}, o_addr, o_wdata);
            end
            ready = 1'b0;
            @(negedge clk);
            nrst = 1'b1;
            return;
         end
      end
      ready = 1'b0;
      for (int j = 0; j < 2; j++) begin
         step(1'b1, 4'hF);
         checks++;
         if ({o_oe, o_rd, o_wr, o_err} !== 4'b0000) begin
            errs++;
            $display("FAIL %s release: oe/rd/wr/err got %b want 0000", nm, {o_oe, o_rd, o_wr, o_err});
         end
      end
   endtask

   task automatic test_reset();
      sel = 1'b0; nrst = 1'b0; lframe = 1'b1; lad_in = 4'hF; ready = 1'b0; rdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_oe, o_lad, o_rd, o_wr, o_err, o_addr, o_wdata} !== {1'b0, 4'hF, 3'b000, 16'h0000, 8'h00}) begin
         errs++;
         $display("FAIL reset: oe/lad/rd/wr/err/addr/wdata got %b %h %b %h %h want 0 f 000 0000 00",
                  o_oe, o_lad, {o_rd, o_wr, o_err}, o_addr, o_wdata);
      end
      @(negedge clk);
      nrst = 1'b1;
      step(1'b1, 4'hF);
   endtask

   task automatic test_write_zero_wait();
      sel = 1'b0;
      run_io("write0", 1'b1, 16'h0080, 8'hA5, 0, 8'h00, -1, 1'b0);
   endtask

   task automatic test_read_wait3();
      sel = 1'b0;
      run_io("read_wait3", 1'b0, 16'h0080, 8'h00, 3, 8'h3C, -1, 1'b0);
   endtask

   task automatic test_mask();
      sel = 1'b0;
      run_io("mask_miss", 1'b0, 16'h0081, 8'h00, 0, 8'h55, -1, 1'b0);
      sel = 1'b1;
      run_io("mask_hit", 1'b0, 16'h0081, 8'h00, 0, 8'h55, -1, 1'b0);
      sel = 1'b0;
   endtask

   task automatic test_timeout();
      sel = 1'b0;
      run_io("wait_max", 1'b0, 16'h0080, 8'h00, MAXW, 8'h7E, -1, 1'b0);
      run_io("timeout", 1'b0, 16'h0080, 8'h00, MAXW + 1, 8'h12, -1, 1'b0);
      run_io("timeout_wr", 1'b1, 16'h0080, 8'h44, 200, 8'h00, -1, 1'b0);
   endtask

   task automatic test_abort();
      sel = 1'b0;
      run_io("abort", 1'b0, 16'h0080, 8'h00, 5, 8'h11, 2, 1'b0);
      run_io("after_abort", 1'b1, 16'h0080, 8'h5A, 0, 8'h00, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      run_io("rst_mid", 1'b0, 16'h0080, 8'h00, 0, 8'h96, -1, 1'b1);
      step(1'b1, 4'hF);
      run_io("after_rst", 1'b0, 16'h0080, 8'h00, 1, 8'hC3, -1, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] addr;
      for (int n = 0; n < 24; n++) begin
         sel  = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0080 + 16'($urandom_range(0, 15));
         run_io("random", 1'($urandom_range(0, 1)), addr, 8'($urandom),
                int'($urandom_range(0, 10)), 8'($urandom), -1, 1'b0);
         step(1'b1, 4'hF);
      end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait3();
      test_mask();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lpc_io_periph.md
Name: lpc_io_periph

Overview:
Parametrised LPC I/O-cycle peripheral. It decodes host I/O read and write cycles against a maskable address window and hands matching accesses to a local register block over a request/ready handshake. It inserts long-wait SYNCs until the local side is ready, and signals error SYNC on timeout. It sits between the board LAD/LFRAME# pins (tristate buffer at top level) and local register logic.

Parameters:
BASE_ADDR, 16'h0080, I/O base address of decoded window
ADDR_MASK, 16'hFFFF, address bits compared; hit when (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)
MAX_WAIT, 8, max long-wait SYNC cycles before error SYNC (1..255)

Ports:
clk_i  in  1  LPC clock (33 MHz)
nrst_i  in  1  reset, asynchronous, active-low
lframe_i  in  1  LFRAME#, active-low
lad_i  in  4  LAD sampled from pins
lad_o  out  4  LAD value to drive
lad_oe_o  out  1  LAD output enable, active-high
addr_o  out  16  latched cycle address
wdata_o  out  8  latched write data
wr_o  out  1  write request pulse, one clk
rd_o  out  1  read request pulse, one clk
rdata_i  in  8  local read data, valid when ready_i high
ready_i  in  1  local side done
err_o  out  1  one-clk pulse when error SYNC issued
state_o  out  5  current FSM state (debug)

Behaviour:
- Reset (async, nrst_i low): state IDLE. lad_oe_o=0, lad_o=4'hF, wr_o=rd_o=err_o=0, addr_o=0, wdata_o=0, wait counter=0, read latch=0.
- All state and registers update on posedge clk_i. lad_o/lad_oe_o decode from registered state and latches only, so they change just after the rising edge.
- States: IDLE, START, CYC, ADDR0-3, WDATA_L, WDATA_H, TAR1, TAR2, SYNC_WAIT, SYNC_OK, SYNC_ERR, RDATA_L, RDATA_H, PTAR1, PTAR2.
- IDLE -> START when lframe_i=0 and lad_i=0000.
- START with lframe_i=0, lad_i=0000: stay. With lframe_i=0 and another nibble: IDLE.
- START with lframe_i=1: lad_i=0000 (I/O read) or 0010 (I/O write) -> ADDR0, and R/W is latched. Any other nibble -> IDLE.
- ADDR0..ADDR3: address nibbles MSB first into addr_o[15:12]..[3:0].
- After ADDR3: write goes to WDATA_L, read goes to TAR1.
- WDATA_L/H: low nibble, then high nibble, into wdata_o. Then TAR1.
- Hit is evaluated on the full address at the ADDR3 edge.
- Miss: FSM goes to IDLE at the edge leaving ADDR3 (read) or WDATA_H (write). No pulse, lad_oe_o never asserted.
- TAR1: rd_o or wr_o high for exactly this cycle. Host owns the bus, lad_oe_o=0.
- TAR2: lad_oe_o=0. At exit, ready_i=1 -> SYNC_OK (zero-wait, rdata_i latched), else -> SYNC_WAIT with counter=1.
- SYNC_WAIT: drive 0110.
  - Each edge with ready_i=1 -> SYNC_OK, rdata_i latched.
  - Else if counter==MAX_WAIT -> SYNC_ERR.
  - Else counter+1.
  - Result: at most MAX_WAIT consecutive 0110 nibbles.
- SYNC_OK: drive 0000.
- SYNC_ERR: drive 1010, err_o high this cycle, read latch forced to 8'hFF. ready_i is ignored from here to IDLE.
- After SYNC_OK/SYNC_ERR: read -> RDATA_L (latch[3:0]) -> RDATA_H (latch[7:4]) -> PTAR1. Write -> PTAR1.
- PTAR1 drives 1111. PTAR2 sets lad_oe_o=0, then IDLE.
- Abort: lframe_i=0 in any state other than IDLE/START.
  - Next state is START if lad_i=0000, else IDLE.
  - lad_oe_o=0 from the following cycle.
  - A request already pulsed is abandoned; no further pulses and no SYNC.
- Simultaneous abort and ready_i: abort wins.
- rd_o, wr_o and err_o are never high together.
- Counter wraps never; it saturates at MAX_WAIT and is cleared in TAR2.
- Reset mid-cycle: immediate release of LAD (lad_oe_o=0) and IDLE.

Test Plan:
1. Write 0x0080 <= 0xA5, ready_i tied 1: START 0000, CYC 0010, addr nibbles 0,0,8,0, data 5,A, TAR -> wr_o one pulse with addr_o=0x0080, wdata_o=0xA5. LAD sequence is 0000, 1111, then released. err_o=0.
2. Read 0x0080, ready_i rises so it is first sampled at the 3rd SYNC_WAIT edge, rdata_i=0x3C: rd_o one pulse. LAD 0110 x3, 0000, C, 3, 1111, then released.
3. Read 0x0081 with ADDR_MASK=16'hFFFF: no rd_o, lad_oe_o stays 0, FSM back in IDLE after ADDR3. Repeat with ADDR_MASK=16'hFFF0: the access hits.
4. Read 0x0080, ready_i held 0, MAX_WAIT=8: 0110 x8, then 1010 with err_o pulse, then F, F, 1111, then released.
5. Abort: lframe_i=0 and lad_i=1111 during the 2nd SYNC_WAIT cycle: lad_oe_o=0 the next cycle, state IDLE, no data phase. A new write then completes normally.
6. nrst_i low during RDATA_L: lad_oe_o=0 and all outputs at reset values immediately, without a clock edge.
